conv: RTL and testbench

CONV -- requirements
Module: conv

---
 rtl/conv.sv | 139 +++++++++++++
 tb/tb_conv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/conv.sv
// Streaming non-overlapping convolution: one unsigned sample per accepted cycle,
// one running partial sum per output column, one result pulse per finished window.
module conv #(
    parameter int KERNEL_DIM = 2,
    parameter int KERNEL_CH  = 3,
    parameter int IMG_DIM    = 4,
    parameter int IMG_CH     = 3,
    parameter int OUT_DIM    = 2,
    parameter int INPUT_PREC = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INPUT_PREC-1:0]     in_img_stream,
    input  logic                      in_valid,
    input  logic [INPUT_PREC-1:0]     Kernal_weights [0:KERNEL_DIM-1][0:KERNEL_DIM-1][0:KERNEL_CH-1],
    output logic [2*INPUT_PREC-1:0]   out_img_stream,
    output logic                      out_valid
);

    localparam int KW  = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
    localparam int CHW = (IMG_CH > 1) ? $clog2(IMG_CH) : 1;
    localparam int OW  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int PW  = $clog2(IMG_DIM + 1);
    localparam int AW  = 2 * INPUT_PREC;

    localparam logic [PW-1:0]  POS_LAST = PW'(IMG_DIM - 1);
    localparam logic [PW-1:0]  WIN_END  = PW'(OUT_DIM * KERNEL_DIM);
    localparam logic [KW-1:0]  K_LAST   = KW'(KERNEL_DIM - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(IMG_CH - 1);

    // Image position, kernel-relative position and output column index
    logic [PW-1:0]  row_r, row_s, col_r, col_s;
    logic [KW-1:0]  i_r, i_s, j_r, j_s;
    logic [CHW-1:0] ch_r, ch_s;
    logic [OW-1:0]  c_r, c_s;

    logic [AW-1:0]  psum_r [0:OUT_DIM-1];
    logic [AW-1:0]  out_data_r;
    logic           out_valid_r;

    logic [AW-1:0]  prod_s;
    logic [AW-1:0]  acc_s;
    logic           in_win_s;
    logic           win_first_s;
    logic           win_last_s;

    assign out_img_stream = out_data_r;
    assign out_valid      = out_valid_r;

    // Product and window-relative accumulate for the sample presented this cycle
    always_comb begin
        prod_s      = AW'(in_img_stream) * AW'(Kernal_weights[i_r][j_r][ch_r]);
        in_win_s    = (row_r < WIN_END) && (col_r < WIN_END);
        win_first_s = (i_r == {KW{1'b0}}) && (j_r == {KW{1'b0}}) && (ch_r == {CHW{1'b0}});
        win_last_s  = (i_r == K_LAST) && (j_r == K_LAST) && (ch_r == CH_LAST);
        if (win_first_s) begin
            acc_s = prod_s;
        end else begin
            acc_s = psum_r[c_r] + prod_s;
        end
    end

    // Next position; counters only move on accepted samples and wrap at frame end
    always_comb begin
        row_s = row_r;
        col_s = col_r;
        i_s   = i_r;
        j_s   = j_r;
        ch_s  = ch_r;
        c_s   = c_r;
        if (in_valid) begin
            if (ch_r == CH_LAST) begin
                ch_s = {CHW{1'b0}};
                if (col_r == POS_LAST) begin
                    col_s = {PW{1'b0}};
                    j_s   = {KW{1'b0}};
                    c_s   = {OW{1'b0}};
                    if (row_r == POS_LAST) begin
                        row_s = {PW{1'b0}};
                        i_s   = {KW{1'b0}};
                    end else begin
                        row_s = row_r + {{(PW-1){1'b0}}, 1'b1};
                        i_s   = (i_r == K_LAST) ? {KW{1'b0}} : i_r + {{(KW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    col_s = col_r + {{(PW-1){1'b0}}, 1'b1};
                    if (j_r == K_LAST) begin
                        j_s = {KW{1'b0}};
                        c_s = c_r + {{(OW-1){1'b0}}, 1'b1};
                    end else begin
                        j_s = j_r + {{(KW-1){1'b0}}, 1'b1};
                        c_s = c_r;
                    end
                end
            end else begin
                ch_s = ch_r + {{(CHW-1){1'b0}}, 1'b1};
            end
        end else begin
            ch_s = ch_r;
        end
    end

    // State registers, partial sums and the registered result
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_r       <= {PW{1'b0}};
            col_r       <= {PW{1'b0}};
            i_r         <= {KW{1'b0}};
            j_r         <= {KW{1'b0}};
            ch_r        <= {CHW{1'b0}};
            c_r         <= {OW{1'b0}};
            out_data_r  <= {AW{1'b0}};
            out_valid_r <= 1'b0;
            for (int n = 0; n < OUT_DIM; n++) begin
                psum_r[n] <= {AW{1'b0}};
            end
        end else begin
            row_r       <= row_s;
            col_r       <= col_s;
            i_r         <= i_s;
            j_r         <= j_s;
            ch_r        <= ch_s;
            c_r         <= c_s;
            out_valid_r <= 1'b0;
            if (in_valid && in_win_s) begin
                psum_r[c_r] <= acc_s;
                if (win_last_s) begin
                    out_data_r  <= acc_s;
                    out_valid_r <= 1'b1;
                end else begin
                    out_data_r  <= out_data_r;
                end
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

endmodule

// File: tb/tb_conv.sv
// Self-checking bench for conv: frame-level reference model plus directed
// literal frames and randomized frames with random valid gaps.
module tb_conv;

    localparam int KD = 2;
    localparam int KC = 3;
    localparam int ID = 4;
    localparam int IC = 3;
    localparam int OD = 2;
    localparam int P  = 8;
    localparam int FRAME = ID * ID * IC;

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   in_img_stream;
    logic           in_valid;
    logic [P-1:0]   w [0:KD-1][0:KD-1][0:KC-1];
    logic [2*P-1:0] out_img_stream;
    logic           out_valid;

    always #5 clk = ~clk;

    conv #(
        .KERNEL_DIM(KD), .KERNEL_CH(KC), .IMG_DIM(ID),
        .IMG_CH(IC), .OUT_DIM(OD), .INPUT_PREC(P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_img_stream(in_img_stream),
        .in_valid(in_valid),
        .Kernal_weights(w),
        .out_img_stream(out_img_stream),
        .out_valid(out_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_n = 0;
    int          pix [0:FRAME-1];
    logic        exp_valid = 1'b0;
    logic [15:0] exp_out = 16'd0;
    bit          armed = 1'b0;
    logic [15:0] got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wsum(input int r, input int c);
        int s;
        s = 0;
        for (int i = 0; i < KD; i++)
            for (int j = 0; j < KD; j++)
                for (int k = 0; k < KC; k++)
                    s += pix[((r*KD+i)*ID + c*KD+j)*IC + k] * int'(w[i][j][k]);
        return s & 32'h0000FFFF;
    endfunction

    task automatic send(input int x, input bit v);
        int ch, col, row;
        in_img_stream = P'(x);
        in_valid = v;
        @(posedge clk);
        exp_valid = 1'b0;
        if (v) begin
            pix[m_n] = x;
            ch  = m_n % IC;
            col = (m_n / IC) % ID;
            row = m_n / (IC * ID);
            if (ch == IC-1 && col % KD == KD-1 && row % KD == KD-1 &&
                col < OD*KD && row < OD*KD) begin
                exp_valid = 1'b1;
                exp_out   = 16'(wsum(row / KD, col / KD));
            end
            m_n = (m_n + 1) % FRAME;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 1'b0);
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b0;
        repeat (cyc) begin
            in_valid = 1'b1;
            in_img_stream = P'($urandom);
            @(posedge clk);
            exp_valid = 1'b0;
            exp_out   = 16'd0;
            m_n       = 0;
            armed     = 1'b1;
            #1;
        end
        rst = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic ramp(input bit asc, input int gap_at, input int gap_len);
        for (int n = 0; n < FRAME; n++) begin
            if (n == gap_at) idle(gap_len);
            send(asc ? n : FRAME-1-n, 1'b1);
        end
    endtask

    task automatic expect4(input string name, input int a, input int b, input int c, input int d);
        int e [4];
        e = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            if (got.size() > 0) check(name, 32'(got.pop_front()), 32'(e[i]));
            else check({name, " missing"}, 32'hFFFFFFFF, 32'(e[i]));
        end
    endtask

    task automatic set_weights(input int mode);
        for (int i = 0; i < KD; i++)
            for (int j = 0; j < KD; j++)
                for (int k = 0; k < KC; k++)
                    w[i][j][k] = (mode == 0) ? P'(i+j+k) : (mode == 1) ? 8'd255 : P'($urandom);
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("out_img_stream", 32'(out_img_stream), 32'(exp_out));
            if (out_valid === 1'b1) got.push_back(out_img_stream);
        end
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_img_stream = '0;
        set_weights(0);
        do_reset(3);
        check("reset out", 32'(out_img_stream), 32'd0);
        check("reset valid", 32'(out_valid), 32'd0);

        ramp(1'b1, -1, 0);
        idle(2);
        expect4("ramp", 257, 401, 833, 977);
        check("ramp count", 32'(got.size()), 32'd0);

        ramp(1'b1, 47, 5);
        idle(2);
        expect4("ramp gap", 257, 401, 833, 977);
        check("ramp gap count", 32'(got.size()), 32'd0);

        ramp(1'b0, 24, 3);
        idle(2);
        expect4("desc gap", 871, 727, 295, 151);
        check("desc gap count", 32'(got.size()), 32'd0);

        ramp(1'b0, -1, 0);
        ramp(1'b1, -1, 0);
        idle(2);
        expect4("b2b desc", 871, 727, 295, 151);
        expect4("b2b asc", 257, 401, 833, 977);
        check("b2b count", 32'(got.size()), 32'd0);

        set_weights(1);
        for (int n = 0; n < FRAME; n++) send(255, 1'b1);
        idle(2);
        expect4("saturate", 59404, 59404, 59404, 59404);
        check("saturate count", 32'(got.size()), 32'd0);

        set_weights(0);
        for (int n = 0; n < 20; n++) send(n, 1'b1);
        idle(1);
        check("pre-reset pulses", 32'(got.size()), 32'd1);
        got.delete();
        do_reset(3);
        ramp(1'b1, -1, 0);
        idle(2);
        expect4("after reset", 257, 401, 833, 977);
        check("after reset count", 32'(got.size()), 32'd0);

        for (int f = 0; f < 6; f++) begin
            set_weights(2);
            for (int n = 0; n < FRAME; n++) begin
                idle($urandom_range(0, 2));
                send(int'($urandom_range(0, 255)), 1'b1);
            end
            idle(2);
            check("random count", 32'(got.size()), 32'(OD*OD));
            got.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
